// File: rtl/demux_1_4_ctrl.sv
// -----------------------------------------------------------------------------
// demux_1_4_ctrl
//   Packet-level controller in front of a 1-to-4 demux datapath. Accepts a
//   valid/ready beat stream and locks the destination on the first beat of
//   each packet. Every beat of that packet is steered through a one-entry
//   output register to exactly one of four sinks. If the locked sink stalls
//   for TIMEOUT consecutive cycles, the held beat is dropped. The rest of that
//   packet is then drained, so a dead sink cannot block the other three.
//
// Parameters
//   DATA_W   payload width
//   TIMEOUT  consecutive stalled cycles before the held beat is dropped (>=1)
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous reset, active-low
//   in_valid   input beat valid
//   in_ready   input beat accepted when in_valid && in_ready (combinational)
//   in_data    input beat payload
//   in_dest    destination 0..3, sampled on the first beat of a packet only
//   in_last    final beat of packet
//   out_valid  one-hot valid, bit index = locked destination
//   out_ready  per-destination ready
//   out_data   payload of the held beat (holds while out_valid == 0)
//   out_last   last flag of the held beat
//   sel        currently locked destination
//   drop_cnt   packets dropped by timeout, saturates at 255
// -----------------------------------------------------------------------------
module demux_1_4_ctrl #(
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [1:0]        in_dest,
  input  logic              in_last,
  output logic [3:0]        out_valid,
  input  logic [3:0]        out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic [1:0]        sel,
  output logic [7:0]        drop_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,  // between packets; next accepted beat is a first beat
    BUSY  = 2'd1,  // mid-packet, destination locked in sel
    DRAIN = 2'd2   // mid-packet after a drop; remaining beats are discarded
  } state_t;

  // stall_cnt never exceeds TIMEOUT-1: the drop clears it on that cycle.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] STALL_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] stall_cnt;

  logic held;       // output register occupied
  logic sink_rdy;   // ready of the locked sink; other ready bits are ignored
  logic handshake;  // held beat handed off this cycle
  logic stall;      // held beat waiting on its sink this cycle
  logic drop;       // final stalled cycle: the held beat is discarded at the edge
  logic accept;     // input beat taken this cycle
  logic load;       // accepted beat is written into the output register

  assign held      = |out_valid;
  assign sink_rdy  = out_ready[sel];
  assign handshake = out_valid[sel] && sink_rdy;
  assign stall     = held && !sink_rdy;
  assign drop      = stall && (stall_cnt == STALL_LAST);
  assign accept    = in_valid && in_ready;
  assign load      = accept && (state != DRAIN);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: the default assignment at the top keeps this block purely
  // combinational; leaving any path unassigned would infer a latch.
  always_comb begin
    state_nxt = state;
    if (drop) begin
      // A held last beat, or a packet whose last beat was already taken,
      // has nothing left to drain.
      state_nxt = (out_last || state == IDLE) ? IDLE : DRAIN;
    end else if (accept) begin
      if (in_last)            state_nxt = IDLE;
      else if (state == IDLE) state_nxt = BUSY;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: output logic
  // ---------------------------------------------------------------------------
  // Outside DRAIN the register can take a new beat when it is empty or when
  // the held beat hands off this cycle, so back-to-back beats see no bubble.
  // In a drop cycle the sink is not ready, so nothing is accepted.
  always_comb begin
    in_ready = 1'b0;
    case (state)
      DRAIN:   in_ready = 1'b1;
      default: in_ready = !held || sink_rdy;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output register, destination lock, stall timer and drop counter
  // ---------------------------------------------------------------------------
  // NOTE: the payload register is reset as well; it is a single entry rather
  // than a memory, and a defined out_data after reset costs nothing.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= '0;
      out_data  <= '0;
      out_last  <= 1'b0;
      sel       <= 2'd0;
      stall_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      if (load) begin
        // First beat of a packet locks a new destination; sel may switch on
        // the same edge the previous packet's last beat hands off.
        if (state == IDLE) begin
          sel       <= in_dest;
          out_valid <= 4'b0001 << in_dest;
        end else begin
          out_valid <= 4'b0001 << sel;
        end
        out_data <= in_data;
        out_last <= in_last;
      end else if (drop || handshake) begin
        out_valid <= '0;
      end

      if (stall && !drop) stall_cnt <= stall_cnt + 1'b1;
      else                stall_cnt <= '0;

      if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_demux_1_4_ctrl.sv
// -----------------------------------------------------------------------------
// tb_demux_1_4_ctrl
//   Scoreboard bench for demux_1_4_ctrl. The driver pushes nothing itself. An
//   observer process watches the input and output handshakes on the falling
//   edge. It keeps a packet-level reference: a queue of beats that should
//   still reach a sink, the locked destination of the current packet, a
//   "discard rest of packet" flag, and a stall timer per held beat. Every
//   cycle it compares the DUT against that reference.
// -----------------------------------------------------------------------------
module tb_demux_1_4_ctrl;

  localparam int DATA_W  = 8;
  localparam int TIMEOUT = 15;
  localparam int BUDGET  = 64;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [1:0]        in_dest;
  logic              in_last;
  logic [3:0]        out_valid;
  logic [3:0]        out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic [1:0]        sel;
  logic [7:0]        drop_cnt;

  demux_1_4_ctrl #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_dest   (in_dest),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .sel       (sel),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [1:0]        dest;
    logic [DATA_W-1:0] data;
    logic              last;
  } beat_t;

  beat_t             exp_q[$];       // beats still owed to a sink, oldest first
  logic [1:0]        m_sel;          // destination of the most recent packet
  logic [DATA_W-1:0] m_data;         // payload of the most recently loaded beat
  logic              m_last;
  bit                m_in_pkt;       // a packet's first beat taken, last not yet
  bit                m_discard;      // remaining beats of current packet are dropped
  int                m_stall;        // cycles the current front beat has waited
  int                m_drops;
  bit                live = 1'b0;    // reference valid (a reset edge has occurred)

  always @(negedge clk) begin
    logic [3:0] exp_valid;
    logic       exp_rdy;
    beat_t      b;

    exp_valid = (exp_q.size() != 0) ? (4'b0001 << exp_q[0].dest) : 4'b0000;
    exp_rdy   = m_discard || (exp_q.size() == 0) ||
                (exp_q.size() != 0 && out_ready[exp_q[0].dest]);

    if (live) begin
      check("out_valid", 32'(out_valid), 32'(exp_valid));
      check("in_ready",  32'(in_ready),  32'(exp_rdy));
      check("sel",       32'(sel),       32'(m_sel));
      check("out_data",  32'(out_data),  32'(m_data));
      check("out_last",  32'(out_last),  32'(m_last));
      check("drop_cnt",  32'(drop_cnt),  32'(m_drops));
    end

    if (!rst_n) begin
      exp_q.delete();
      m_sel     = 2'd0;
      m_data    = '0;
      m_last    = 1'b0;
      m_in_pkt  = 1'b0;
      m_discard = 1'b0;
      m_stall   = 0;
      m_drops   = 0;
      live      = 1'b1;
    end else if (live) begin
      // Output side: hand-off, or another stalled cycle that may expire.
      if (exp_q.size() != 0) begin
        if (out_ready[exp_q[0].dest]) begin
          void'(exp_q.pop_front());
          m_stall = 0;
        end else begin
          m_stall++;
          if (m_stall == TIMEOUT) begin
            b = exp_q.pop_front();
            m_stall = 0;
            if (m_drops < 255) m_drops++;
            if (!b.last) m_discard = 1'b1;
          end
        end
      end else begin
        m_stall = 0;
      end

      // Input side.
      if (in_valid && exp_rdy) begin
        if (!m_in_pkt && !m_discard) m_sel = in_dest;
        if (m_discard) begin
          if (in_last) m_discard = 1'b0;
        end else begin
          b.dest = m_sel;
          b.data = in_data;
          b.last = in_last;
          exp_q.push_back(b);
          m_data = in_data;
          m_last = in_last;
        end
        m_in_pkt = !in_last;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Random sink: each output randomly ready, with sinks going dead for long
  // stretches so timeouts occur.
  // ---------------------------------------------------------------------------
  bit       rand_sink = 1'b0;
  bit [3:0] dead      = 4'b0000;

  always @(posedge clk) begin
    #1;
    if (rand_sink) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 199) == 0) dead[i] = ~dead[i];
        out_ready[i] = !dead[i] && ($urandom_range(0, 3) != 0);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver. Called 1 time unit after a rising edge; returns 1 time unit after
  // the edge that accepted the beat.
  // ---------------------------------------------------------------------------
  task automatic send_beat(input logic [1:0] d, input logic [DATA_W-1:0] dat, input logic last);
    bit done = 1'b0;
    int n    = 0;
    in_valid = 1'b1;
    in_dest  = d;
    in_data  = dat;
    in_last  = last;
    while (!done) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk);
      #1;
      n++;
      if (!done && n >= BUDGET) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: beat %0h not accepted in %0d cycles", dat, BUDGET);
        done = 1'b1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    // 1. Reset with in_valid asserted.
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'hEE;
    in_dest   = 2'd3;
    in_last   = 1'b0;
    out_ready = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_drop_cnt",  32'(drop_cnt),  32'd0);
    check("reset_sel",       32'(sel),       32'd0);
    idle_cycles(1);

    // 2. Three-beat packet to sink 2, sink always ready.
    out_ready = 4'b0100;
    send_beat(2'd2, 8'hA1, 1'b0);
    check("t2_first_latency", 32'(out_valid), 32'h4);
    send_beat(2'd2, 8'hA2, 1'b0);
    send_beat(2'd2, 8'hA3, 1'b1);
    check("t2_last_flag", 32'(out_last), 32'd1);
    idle_cycles(3);

    // 3. Back-to-back packets; dest on a non-first beat is ignored.
    out_ready = 4'b1111;
    send_beat(2'd1, 8'hB1, 1'b1);
    send_beat(2'd3, 8'hC1, 1'b0);
    check("t3_sel_switch", 32'(sel), 32'd3);
    send_beat(2'd0, 8'hC2, 1'b0 | 1'b1);
    check("t3_dest_ignored", 32'(out_valid), 32'h8);
    idle_cycles(3);

    // 4. Dead sink 0: beat 1 times out, beats 2-4 are drained.
    out_ready = 4'b1110;
    send_beat(2'd0, 8'hD1, 1'b0);
    send_beat(2'd0, 8'hD2, 1'b0);
    send_beat(2'd0, 8'hD3, 1'b0);
    send_beat(2'd0, 8'hD4, 1'b1);
    check("t4_drop_cnt", 32'(drop_cnt), 32'd1);
    check("t4_no_output", 32'(out_valid), 32'd0);
    idle_cycles(2);

    // 5. Sink 2 stalls 14 cycles (one short of the timeout); others ready.
    out_ready = 4'b1011;
    send_beat(2'd2, 8'hE1, 1'b1);
    idle_cycles(14);
    check("t5_still_held", 32'(out_valid), 32'h4);
    out_ready = 4'b0100;
    idle_cycles(1);
    check("t5_delivered", 32'(out_valid), 32'd0);
    check("t5_drop_cnt", 32'(drop_cnt), 32'd1);
    idle_cycles(2);

    // 6a. Saturation: 256 dropped single-beat packets.
    out_ready = 4'b0111;
    for (int i = 0; i < 256; i++) send_beat(2'd3, 8'(i), 1'b1);
    idle_cycles(TIMEOUT + 2);
    check("t6_saturated", 32'(drop_cnt), 32'd255);

    // 6b. Reset while BUSY, then a fresh packet routes from IDLE.
    out_ready = 4'b1111;
    send_beat(2'd1, 8'hF1, 1'b0);
    send_beat(2'd1, 8'hF2, 1'b0);
    rst_n = 1'b0;
    idle_cycles(2);
    rst_n = 1'b1;
    check("t6_reset_drop_cnt", 32'(drop_cnt), 32'd0);
    check("t6_reset_valid", 32'(out_valid), 32'd0);
    send_beat(2'd2, 8'h61, 1'b1);
    check("t6_new_pkt_valid", 32'(out_valid), 32'h4);
    check("t6_new_pkt_sel", 32'(sel), 32'd2);
    idle_cycles(2);

    // 7. Randomized packets against random, occasionally dead sinks.
    dead      = 4'b0000;
    rand_sink = 1'b1;
    for (int p = 0; p < 300; p++) begin
      logic [1:0] d;
      int         nb;
      d  = 2'($urandom_range(0, 3));
      nb = $urandom_range(1, 4);
      for (int k = 0; k < nb; k++) begin
        if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 2));
        send_beat((k == 0) ? d : 2'($urandom_range(0, 3)),
                  8'($urandom_range(0, 255)), (k == nb - 1));
      end
    end
    rand_sink = 1'b0;
    out_ready = 4'b1111;
    idle_cycles(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
